// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  localparam logic RES_ALU   = 1'b0;
  localparam logic RES_SHIFT = 1'b1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  cad;
    logic              gp_we;
  } wb_fields_t;

  function automatic logic [DATA_W-1:0] select_result(
    input logic              sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] shift
  );
    logic [DATA_W-1:0] r;
    case (sel)
      RES_ALU:   r = alu;
      RES_SHIFT: r = shift;
      default:   r = alu;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Saturating cycle counter that flags when a bus access has waited
// TIMEOUT_CYCLES cycles (expired is high in the final allowed cycle).
module dmem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 32'd1));

endmodule

// File: rtl/memory_stage.sv
// MIPS memory-access stage: word loads/stores over a req/ack bus,
// registered write-back fields and single-cycle exception pulses.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_shift_res,
  input  logic              ex_res_sel,
  input  logic [DATA_W-1:0] ex_ea,
  input  logic [DATA_W-1:0] ex_dm_in,
  input  logic              ex_ovfalu,
  input  logic              ex_mem_wren,
  input  logic              ex_mem_rden,
  input  logic              ex_gp_we,
  input  logic [REG_W-1:0]  ex_cad,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_cad,
  output logic              wb_gp_we,
  output logic              exc_ovf,
  output logic              exc_align,
  output logic              exc_bus
);

  state_t           state, state_d;
  dmem_cmd_t        cmd_q, cmd_d;
  wb_fields_t       wb_q, wb_d;
  logic             req_d, wb_valid_d;
  logic             exc_ovf_d, exc_align_d, exc_bus_d;
  logic             load_q, load_d, gp_we_q, gp_we_d, kill_q, kill_d;
  logic [REG_W-1:0] cad_q, cad_d;
  logic             accept, mem_op, killed;
  logic             wd_clr, wd_en, wd_expired;

  assign ex_ready = (state == IDLE) && !reset && !flush;
  assign accept   = ex_valid && ex_ready;
  assign mem_op   = ex_mem_wren || ex_mem_rden;
  assign wd_en    = (state == ACCESS);

  assign dmem_we    = cmd_q.we;
  assign dmem_addr  = cmd_q.addr;
  assign dmem_wdata = cmd_q.wdata;
  assign wb_data    = wb_q.data;
  assign wb_cad     = wb_q.cad;
  assign wb_gp_we   = wb_q.gp_we;

  dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dmem_req  <= 1'b0;
      cmd_q     <= '0;
      wb_q      <= '0;
      wb_valid  <= 1'b0;
      exc_ovf   <= 1'b0;
      exc_align <= 1'b0;
      exc_bus   <= 1'b0;
      load_q    <= 1'b0;
      gp_we_q   <= 1'b0;
      cad_q     <= '0;
      kill_q    <= 1'b0;
    end else begin
      state     <= state_d;
      dmem_req  <= req_d;
      cmd_q     <= cmd_d;
      wb_q      <= wb_d;
      wb_valid  <= wb_valid_d;
      exc_ovf   <= exc_ovf_d;
      exc_align <= exc_align_d;
      exc_bus   <= exc_bus_d;
      load_q    <= load_d;
      gp_we_q   <= gp_we_d;
      cad_q     <= cad_d;
      kill_q    <= kill_d;
    end
  end

  always_comb begin
    state_d     = state;
    req_d       = dmem_req;
    cmd_d       = cmd_q;
    wb_d        = wb_q;
    wb_valid_d  = 1'b0;
    exc_ovf_d   = 1'b0;
    exc_align_d = 1'b0;
    exc_bus_d   = 1'b0;
    load_d      = load_q;
    gp_we_d     = gp_we_q;
    cad_d       = cad_q;
    kill_d      = kill_q;
    killed      = 1'b0;
    wd_clr      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          // Overflow outranks alignment and suppresses any bus access.
          if (ex_ovfalu) begin
            wb_valid_d = 1'b1;
            exc_ovf_d  = 1'b1;
            wb_d.data  = select_result(ex_res_sel, ex_alu_res, ex_shift_res);
            wb_d.cad   = ex_cad;
            wb_d.gp_we = 1'b0;
          end else if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_d.data  = select_result(ex_res_sel, ex_alu_res, ex_shift_res);
            wb_d.cad   = ex_cad;
            wb_d.gp_we = ex_gp_we;
          end else if (ex_ea[1:0] != 2'b00) begin
            wb_valid_d  = 1'b1;
            exc_align_d = 1'b1;
            wb_d.cad    = ex_cad;
            wb_d.gp_we  = 1'b0;
          end else begin
            req_d       = 1'b1;
            cmd_d.we    = ex_mem_wren;
            cmd_d.addr  = ex_ea;
            cmd_d.wdata = ex_dm_in;
            load_d      = ex_mem_rden;
            gp_we_d     = ex_gp_we;
            cad_d       = ex_cad;
            kill_d      = 1'b0;
            wd_clr      = 1'b1;
            state_d     = ACCESS;
          end
        end
      end

      ACCESS: begin
        // A flush lets the bus cycle finish but swallows its write-back.
        killed = kill_q || flush;
        kill_d = killed;
        if (dmem_ack || wd_expired) begin
          req_d   = 1'b0;
          kill_d  = 1'b0;
          state_d = IDLE;
          if (!killed) begin
            wb_valid_d = 1'b1;
            wb_d.cad   = cad_q;
            wb_d.gp_we = 1'b0;
            if (dmem_ack) begin
              if (load_q) begin
                wb_d.data  = dmem_rdata;
                wb_d.gp_we = gp_we_q;
              end
            end else begin
              exc_bus_d = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a randomized
// instruction stream checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_memory_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_alu_res = '0, ex_shift_res = '0, ex_ea = '0, ex_dm_in = '0;
  logic        ex_res_sel = 1'b0, ex_ovfalu = 1'b0, ex_mem_wren = 1'b0, ex_mem_rden = 1'b0;
  logic        ex_gp_we = 1'b0, flush = 1'b0;
  logic [4:0]  ex_cad = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_valid, wb_gp_we, exc_ovf, exc_align, exc_bus;
  logic [31:0] wb_data;
  logic [4:0]  wb_cad;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rd, wr, sel, ovf, gpwe;
    logic [31:0] alu, sh, ea, din;
    logic [4:0] cad;
    int lat;  // req cycles before the ack cycle; -1 = never ack
  } op_t;

  typedef struct {
    int lat, reqc, busy;
    logic rdy, gpwe, eo, ea, eb;
    logic [31:0] data;
    logic [4:0] cad;
  } obs_t;

  typedef struct {
    int lat, reqc;
    logic chk, gpwe, eo, ea, eb;
    logic [31:0] data;
    logic [4:0] cad;
  } exp_t;

  memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_res(ex_alu_res), .ex_shift_res(ex_shift_res), .ex_res_sel(ex_res_sel),
    .ex_ea(ex_ea), .ex_dm_in(ex_dm_in), .ex_ovfalu(ex_ovfalu),
    .ex_mem_wren(ex_mem_wren), .ex_mem_rden(ex_mem_rden), .ex_gp_we(ex_gp_we),
    .ex_cad(ex_cad), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_cad(wb_cad), .wb_gp_we(wb_gp_we),
    .exc_ovf(exc_ovf), .exc_align(exc_align), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  // Test memory: untouched words read as a fixed hash of their address.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int ack_lat = -1;
  int req_seen = 0;
  bit ack_noise = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory device: acks in req cycle ack_lat+1; optional ack noise while idle.
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      req_seen = req_seen + 1;
      if (ack_lat >= 0 && req_seen == ack_lat + 1) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dev_rd(dmem_addr);
        if (dmem_we) dev_mem[dmem_addr] = dmem_wdata;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
    end else begin
      req_seen   = 0;
      dmem_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dmem_rdata = $urandom;
    end
  end

  function automatic op_t mk(input logic rd, input logic wr, input logic [31:0] alu,
                             input logic [31:0] sh, input logic sel, input logic [31:0] ea,
                             input logic [31:0] din, input logic ovf, input logic gpwe,
                             input logic [4:0] cad, input int lat);
    op_t o;
    o.rd = rd; o.wr = wr; o.alu = alu; o.sh = sh; o.sel = sel; o.ea = ea;
    o.din = din; o.ovf = ovf; o.gpwe = gpwe; o.cad = cad; o.lat = lat;
    return o;
  endfunction

  // Drives one transfer and waits (bounded) for the resulting wb_valid pulse.
  task automatic issue(input op_t o, output obs_t r);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_rden = o.rd; ex_mem_wren = o.wr; ex_alu_res = o.alu;
    ex_shift_res = o.sh; ex_res_sel = o.sel; ex_ea = o.ea; ex_dm_in = o.din;
    ex_ovfalu = o.ovf; ex_gp_we = o.gpwe; ex_cad = o.cad; ack_lat = o.lat;
    r.rdy = ex_ready;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    r.lat = 1; r.reqc = 0; r.busy = 0;
    while (wb_valid !== 1'b1 && r.lat < 40) begin
      if (dmem_req === 1'b1) r.reqc++;
      if (dmem_req === 1'b1 && ex_ready !== 1'b0) r.busy++;
      @(posedge clk); #1;
      r.lat++;
    end
    r.data = wb_data; r.cad = wb_cad; r.gpwe = wb_gp_we;
    r.eo = exc_ovf; r.ea = exc_align; r.eb = exc_bus;
  endtask

  // Reference model: outcome of one instruction from the stage's rules.
  task automatic predict(input op_t o, output exp_t e);
    logic mem;
    mem = o.rd | o.wr;
    e.lat = 1; e.reqc = 0; e.chk = 1'b0; e.gpwe = 1'b0; e.data = '0; e.cad = o.cad;
    e.eo = 1'b0; e.ea = 1'b0; e.eb = 1'b0;
    if (o.ovf) begin
      e.eo = 1'b1;
      e.chk = !mem;
      e.data = o.sel ? o.sh : o.alu;
    end else if (!mem) begin
      e.chk = 1'b1; e.data = o.sel ? o.sh : o.alu; e.gpwe = o.gpwe;
    end else if (o.ea[1:0] != 2'b00) begin
      e.ea = 1'b1;
    end else if (o.lat < 0 || o.lat >= int'(TO)) begin
      e.eb = 1'b1; e.reqc = int'(TO); e.lat = int'(TO) + 1;
    end else begin
      e.reqc = o.lat + 1; e.lat = o.lat + 2;
      if (o.rd) begin
        e.chk = 1'b1; e.data = ref_rd(o.ea); e.gpwe = o.gpwe;
      end else begin
        ref_mem[o.ea] = o.din;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b1; ex_mem_rden = 1'b1; ex_ea = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({wb_valid, wb_gp_we, dmem_req, dmem_we, exc_ovf, exc_align, exc_bus, ex_ready} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000",
        {wb_valid, wb_gp_we, dmem_req, dmem_we, exc_ovf, exc_align, exc_bus, ex_ready}); end
    checks++; if ({wb_data, wb_cad, dmem_addr, dmem_wdata} !== 101'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want all zero", wb_data, wb_cad, dmem_addr, dmem_wdata); end
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_rden = 1'b0; reset = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_release ex_ready: got %b want 1", ex_ready); end
  endtask

  task automatic test_nonmem();
    obs_t r;
    issue(mk(0, 0, 32'h10, 32'hFFFF, 0, 32'h3, 0, 0, 1, 5, 0), r);
    checks++; if (r.lat != 1) begin errors++; $display("FAIL nonmem latency: got %0d want 1", r.lat); end
    checks++; if ({r.data, r.cad, r.gpwe} !== {32'h10, 5'd5, 1'b1}) begin
      errors++; $display("FAIL nonmem fields: got %h/%0d/%b want 00000010/5/1", r.data, r.cad, r.gpwe); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h10) begin
      errors++; $display("FAIL nonmem pulse/hold: got valid=%b data=%h want 0/00000010", wb_valid, wb_data); end
    issue(mk(0, 0, 32'h1, 32'h0000_1234, 1, 0, 0, 0, 0, 17, 0), r);
    checks++; if ({r.data, r.cad, r.gpwe} !== {32'h1234, 5'd17, 1'b0}) begin
      errors++; $display("FAIL nonmem shift_sel: got %h/%0d/%b want 00001234/17/0", r.data, r.cad, r.gpwe); end
  endtask

  task automatic test_load();
    obs_t r;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    issue(mk(1, 0, 0, 0, 0, 32'h100, 0, 0, 1, 7, 2), r);
    checks++; if (r.reqc != 3 || r.lat != 4) begin
      errors++; $display("FAIL load timing: got req=%0d lat=%0d want 3/4", r.reqc, r.lat); end
    checks++; if (r.busy != 0) begin errors++; $display("FAIL load ex_ready: got %0d busy-ready cycles want 0", r.busy); end
    checks++; if ({r.data, r.cad, r.gpwe, r.eb} !== {32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL load fields: got %h/%0d/%b bus=%b want deadbeef/7/1 bus=0", r.data, r.cad, r.gpwe, r.eb); end
    issue(mk(1, 0, 0, 0, 0, 32'h104, 0, 0, 1, 2, 0), r);
    checks++; if (r.reqc != 1 || r.lat != 2 || r.data !== init_word(32'h104)) begin
      errors++; $display("FAIL load zero_wait: got req=%0d lat=%0d data=%h want 1/2/%h", r.reqc, r.lat, r.data, init_word(32'h104)); end
  endtask

  task automatic test_align();
    obs_t r;
    issue(mk(0, 1, 0, 0, 0, 32'h102, 32'h1111, 0, 1, 3, 0), r);
    checks++; if (r.reqc != 0 || r.lat != 1) begin
      errors++; $display("FAIL align timing: got req=%0d lat=%0d want 0/1", r.reqc, r.lat); end
    checks++; if ({r.ea, r.eo, r.eb, r.gpwe} !== 4'b1000) begin
      errors++; $display("FAIL align flags: got al=%b ov=%b bus=%b gpwe=%b want 1/0/0/0", r.ea, r.eo, r.eb, r.gpwe); end
  endtask

  task automatic test_timeout();
    obs_t r;
    issue(mk(1, 0, 0, 0, 0, 32'h200, 0, 0, 1, 9, -1), r);
    checks++; if (r.reqc != int'(TO) || r.lat != int'(TO) + 1) begin
      errors++; $display("FAIL timeout timing: got req=%0d lat=%0d want %0d/%0d", r.reqc, r.lat, TO, TO + 1); end
    checks++; if ({r.eb, r.gpwe, dmem_req, ex_ready} !== 4'b1001) begin
      errors++; $display("FAIL timeout state: got bus=%b gpwe=%b req=%b rdy=%b want 1/0/0/1", r.eb, r.gpwe, dmem_req, ex_ready); end
    @(posedge clk); #1;
    checks++; if (exc_bus !== 1'b0) begin errors++; $display("FAIL timeout pulse: got exc_bus=%b want 0", exc_bus); end
    // Ack landing in the final allowed cycle beats the timeout.
    issue(mk(1, 0, 0, 0, 0, 32'h204, 0, 0, 1, 4, int'(TO) - 1), r);
    checks++; if (r.reqc != int'(TO) || r.eb !== 1'b0 || r.data !== init_word(32'h204) || r.gpwe !== 1'b1) begin
      errors++; $display("FAIL ack_vs_timeout: got req=%0d bus=%b data=%h gpwe=%b want %0d/0/%h/1",
        r.reqc, r.eb, r.data, r.gpwe, TO, init_word(32'h204)); end
  endtask

  task automatic test_ovf();
    obs_t r;
    issue(mk(0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 1, 1, 9, 0), r);
    checks++; if ({r.eo, r.gpwe, r.data} !== {1'b1, 1'b0, 32'h7FFF_FFFF} || r.lat != 1) begin
      errors++; $display("FAIL ovf add: got ov=%b gpwe=%b data=%h lat=%0d want 1/0/7fffffff/1", r.eo, r.gpwe, r.data, r.lat); end
    issue(mk(1, 0, 0, 0, 0, 32'h301, 0, 1, 1, 6, 0), r);
    checks++; if ({r.eo, r.ea, r.eb, r.gpwe} !== 4'b1000 || r.reqc != 0) begin
      errors++; $display("FAIL ovf priority: got ov=%b al=%b bus=%b gpwe=%b req=%0d want 1/0/0/0/0", r.eo, r.ea, r.eb, r.gpwe, r.reqc); end
  endtask

  task automatic test_flush();
    int seen;
    obs_t r;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_rden = 1'b0; ex_mem_wren = 1'b0; ex_ovfalu = 1'b0; flush = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL flush_idle ex_ready: got %b want 0", ex_ready); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_idle wb_valid: got %b want 0", wb_valid); end
    @(negedge clk);
    flush = 1'b0; ex_mem_wren = 1'b1; ex_ea = 32'h40; ex_dm_in = 32'hCAFE_F00D; ex_gp_we = 1'b0; ack_lat = 1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wb_valid === 1'b1 || exc_bus === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_access wb_valid: got %0d pulses want 0", seen); end
    checks++; if (dev_rd(32'h40) !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL flush_access store: got %h want cafef00d", dev_rd(32'h40)); end
    checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL flush_access idle: got req=%b rdy=%b want 0/1", dmem_req, ex_ready); end
    issue(mk(0, 0, 32'h55, 0, 0, 0, 0, 0, 1, 1, 0), r);
    checks++; if (r.lat != 1 || r.data !== 32'h55) begin
      errors++; $display("FAIL flush_kill_cleared: got lat=%0d data=%h want 1/00000055", r.lat, r.data); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_rden = 1'b1; ex_mem_wren = 1'b0; ex_ovfalu = 1'b0; ex_ea = 32'h80; ack_lat = -1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_access: got req=%b rdy=%b want 0/0", dmem_req, ex_ready); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_access release: got rdy=%b want 1", ex_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, s, want;
    logic sel, g;
    logic [4:0] c;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = $urandom; s = $urandom; sel = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1)); c = 5'($urandom_range(0, 31));
      ex_valid = 1'b1; ex_mem_rden = 1'b0; ex_mem_wren = 1'b0; ex_ovfalu = 1'b0;
      ex_alu_res = a; ex_shift_res = s; ex_res_sel = sel; ex_gp_we = g; ex_cad = c;
      want = sel ? s : a;
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] ex_ready: got %b want 1", i, ex_ready); end
      @(posedge clk); #1;
      checks++; if ({wb_valid, wb_data, wb_cad, wb_gp_we} !== {1'b1, want, c, g}) begin
        errors++; $display("FAIL b2b[%0d] wb: got %b/%h/%0d/%b want 1/%h/%0d/%b", i, wb_valid, wb_data, wb_cad, wb_gp_we, want, c, g); end
    end
    @(negedge clk); ex_valid = 1'b0;
  endtask

  task automatic test_random();
    op_t o;
    obs_t r;
    exp_t e;
    int k;
    dev_mem.delete(); ref_mem.delete();
    ack_noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 2));
      o.rd = (k == 1); o.wr = (k == 2);
      o.alu = $urandom; o.sh = $urandom; o.din = $urandom;
      o.sel = 1'($urandom_range(0, 1)); o.gpwe = 1'($urandom_range(0, 1));
      o.cad = 5'($urandom_range(0, 31)); o.ovf = ($urandom_range(0, 9) == 0);
      o.ea = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 5) == 0) o.ea = o.ea | 32'($urandom_range(1, 3));
      o.lat = int'($urandom_range(0, 6));
      if (o.lat == 6) o.lat = -1;
      predict(o, e);
      issue(o, r);
      checks++; if (r.rdy !== 1'b1 || r.busy != 0) begin
        errors++; $display("FAIL rand[%0d] ready: got rdy=%b busy=%0d want 1/0", i, r.rdy, r.busy); end
      checks++; if (r.lat != e.lat || r.reqc != e.reqc) begin
        errors++; $display("FAIL rand[%0d] timing: got lat=%0d req=%0d want %0d/%0d", i, r.lat, r.reqc, e.lat, e.reqc); end
      checks++; if ({r.eo, r.ea, r.eb, r.gpwe} !== {e.eo, e.ea, e.eb, e.gpwe}) begin
        errors++; $display("FAIL rand[%0d] flags: got %b%b%b%b want %b%b%b%b", i, r.eo, r.ea, r.eb, r.gpwe, e.eo, e.ea, e.eb, e.gpwe); end
      if (e.chk) begin
        checks++; if (r.data !== e.data || r.cad !== e.cad) begin
          errors++; $display("FAIL rand[%0d] data: got %h/%0d want %h/%0d", i, r.data, r.cad, e.data, e.cad); end
      end
    end
    ack_noise = 1'b0;
    for (int w = 0; w < 16; w++) begin
      checks++; if (dev_rd(32'(w) << 2) !== ref_rd(32'(w) << 2)) begin
        errors++; $display("FAIL rand mem[%0d]: got %h want %h", w, dev_rd(32'(w) << 2), ref_rd(32'(w) << 2)); end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_align();
    test_timeout();
    test_ovf();
    test_flush();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the MIPS pipeline, directly downstream of the execute stage. Takes the execute results (ALU result, shift result, effective address, store data, overflow flag) plus control fields, performs word loads/stores over a request/acknowledge data-memory bus, and registers the write-back fields for the write-back stage. While a bus access is outstanding it back-pressures execute through `ex_ready`.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles `dmem_req` may wait for `dmem_ack` before the access is aborted with a bus error.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: execute presents a valid instruction.
- `ex_ready` out 1: stage accepts this cycle; `ex_valid && ex_ready` is a transfer.
- `ex_alu_res`, `ex_shift_res` in 32: execute results.
- `ex_res_sel` in 1: 0 selects ALU result, 1 selects shift result for non-load write-back.
- `ex_ea` in 32: effective address.
- `ex_dm_in` in 32: store data.
- `ex_ovfalu` in 1: ALU overflow.
- `ex_mem_wren`, `ex_mem_rden` in 1: store / load; never both set.
- `ex_gp_we` in 1: instruction writes a GPR.
- `ex_cad` in 5: destination register.
- `flush` in 1: discard the current and pending write-back.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32: memory request.
- `dmem_rdata` in 32, `dmem_ack` in 1: memory response; `dmem_rdata` is valid in the ack cycle.
- `wb_valid` out 1, `wb_data` out 32, `wb_cad` out 5, `wb_gp_we` out 1: write-back fields.
- `exc_ovf`, `exc_align`, `exc_bus` out 1: single-cycle exception pulses aligned with `wb_valid`.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: `ex_ready = !reset`. On transfer:
  - Non-memory instruction: next cycle `wb_valid=1`, `wb_data` = selected result, `wb_cad=ex_cad`, `wb_gp_we = ex_gp_we && !ex_ovfalu`, `exc_ovf = ex_ovfalu`. Stay in IDLE.
  - Memory instruction with `ex_ea[1:0]!=0`: no bus access. Next cycle `wb_valid=1`, `wb_gp_we=0`, `exc_align=1`.
  - Aligned memory instruction: latch `dmem_addr=ex_ea`, `dmem_wdata=ex_dm_in`, `dmem_we=ex_mem_wren`, `dmem_req=1` from the next cycle; clear the timeout counter; go to ACCESS.
- ACCESS: `ex_ready=0`. `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable.
  - `dmem_ack` high: drop `dmem_req` next cycle. Next cycle `wb_valid=1`. For a load, `wb_data=dmem_rdata` and `wb_gp_we=ex_gp_we` latched at acceptance. For a store, `wb_gp_we=0`. Return to IDLE.
  - Counter reaches `TIMEOUT_CYCLES` without ack: drop `dmem_req`, `wb_valid=1`, `wb_gp_we=0`, `exc_bus=1`, return to IDLE.
- `wb_valid` and `exc_*` are single-cycle pulses. `wb_data`, `wb_cad` and `wb_gp_we` hold their values until the next update.
- `flush`:
  - In IDLE it suppresses acceptance that cycle; no transfer occurs and `ex_ready` is low.
  - In ACCESS the bus transaction still completes (stores are not cancelled), but the resulting `wb_valid` and `exc_*` are suppressed. A sticky kill bit records this and clears on return to IDLE.
- Any `ex_ovfalu` on a memory instruction is treated as an overflow: no bus access, `exc_ovf=1`, `wb_gp_we=0`.
- Exception priority: ovf > align > bus.

## Timing
- Reset values:
  - `wb_valid`, `wb_data`, `wb_cad`, `wb_gp_we` = 0.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` = 0.
  - All `exc_*` = 0; FSM in IDLE; counter = 0; kill bit = 0.
- `ex_ready` is low while `reset` is high.
- Reset mid-ACCESS drops `dmem_req` at the next edge; the transaction is abandoned.
- Non-memory and exception latency: 1 cycle from transfer to `wb_valid`.
- Memory latency: 1 cycle to `dmem_req`, then N cycles until `dmem_ack`, then 1 cycle to `wb_valid`. A zero-wait memory (ack in the first req cycle) gives 2 cycles total.
- Back-to-back non-memory transfers sustain one per cycle.
- `dmem_ack` is ignored whenever `dmem_req` is low.
- Ack and timeout in the same cycle: the ack wins.

## Structure
- Package `mem_stage_pkg`: the state enum (IDLE, ACCESS), `RES_ALU`/`RES_SHIFT` constants, and the default timeout value.
- Sub-module `dmem_watchdog`: a clear/enable counter with a parameterised width (`$clog2(TIMEOUT_CYCLES+1)`) that raises `expired`.

## Test plan
- Non-memory op: ALU 0x0000_0010, `res_sel=0`, cad=5, gp_we=1 -> next cycle `wb_valid=1`, `wb_data=0x10`, `wb_cad=5`, `wb_gp_we=1`.
- Load from ea=0x100, ack after 3 cycles with rdata 0xDEADBEEF -> `dmem_req` high for 3 cycles, `ex_ready` low, then `wb_data=0xDEADBEEF`, `wb_gp_we=1`.
- Store with ea=0x102 -> no `dmem_req`, `exc_align=1`, `wb_gp_we=0`.
- Load with no ack and `TIMEOUT_CYCLES=4` -> `dmem_req` drops after 4 cycles, `exc_bus=1`, stage back in IDLE with `ex_ready=1`.
- Store accepted, `flush` pulsed during ACCESS, ack after 2 cycles -> the write is performed and no `wb_valid` is produced.
- `ex_ovfalu=1` on an add with gp_we=1 -> `exc_ovf=1`, `wb_gp_we=0`.
